// File: rtl/note_pkg.sv
// Shared types for the note-lane engine: FSM encoding, lane columns, slot record.
// Pure declarations; no logic, no latency, no flow control.
package note_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [9:0] LANE0_X0 = 10'd0;
    localparam logic [9:0] LANE0_X1 = 10'd199;
    localparam logic [9:0] LANE1_X0 = 10'd220;
    localparam logic [9:0] LANE1_X1 = 10'd419;
    localparam logic [9:0] LANE2_X0 = 10'd440;
    localparam logic [9:0] LANE2_X1 = 10'd639;

    typedef struct packed {
        logic       valid;
        logic [1:0] lane;
        logic [9:0] y;
    } slot_t;

    // pattern word layout: {present, lane[1:0]}
    localparam int PAT_PRESENT  = 2;
    localparam int PAT_LANE_LSB = 0;

endpackage

// File: rtl/note_slot_render.sv
// Combinational test of one note slot against the current pixel, one bit per lane.
// Zero latency; no flow control.
module note_slot_render
    import note_pkg::*;
#(
    parameter int NOTE_HALF = 10
) (
    input  slot_t      slot,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    output logic [2:0] lane_hit
);

    logic [10:0] y_lo;
    logic [10:0] y_hi;
    logic        in_y;
    logic        in_col;

    always_comb begin
        // 11-bit bounds: the top edge clamps at 0 and the bottom edge cannot wrap
        y_lo = (slot.y < 10'(NOTE_HALF)) ? 11'd0 : ({1'b0, slot.y} - 11'(NOTE_HALF));
        y_hi = {1'b0, slot.y} + 11'(NOTE_HALF);
        in_y = ({1'b0, counter_y} >= y_lo) && ({1'b0, counter_y} <= y_hi);
        case (slot.lane)
            2'd0:    in_col = (counter_x <= LANE0_X1);
            2'd1:    in_col = (counter_x >= LANE1_X0) && (counter_x <= LANE1_X1);
            2'd2:    in_col = (counter_x >= LANE2_X0) && (counter_x <= LANE2_X1);
            default: in_col = 1'b0;
        endcase
        lane_hit = {slot.lane == 2'd2, slot.lane == 2'd1, slot.lane == 2'd0}
                 & {3{slot.valid & in_y & in_col}};
    end

endmodule

// File: rtl/note_track.sv
// Note-lane engine: pattern-driven spawn into a slot pool, fall, hit judging, miss/score counting.
// Slot/counter updates and lane_on are registered (1 cycle); no backpressure, ticks are enables.
module note_track
    import note_pkg::*;
#(
    parameter int SLOTS     = 8,
    parameter int PAT_LEN   = 16,
    parameter int NOTE_HALF = 10,
    parameter int HIT_Y     = 440,
    parameter int HIT_WIN   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       beat_tick,
    input  logic       move_tick,
    input  logic [2:0] pattern,
    output logic [3:0] pat_addr,
    input  logic [2:0] btn_hit,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    output logic [2:0] lane_on,
    output logic [7:0] score,
    output logic [7:0] miss_count,
    output logic       overflow,
    output logic [1:0] state
);

    localparam logic [9:0] WIN_LO = 10'(HIT_Y - HIT_WIN);
    localparam logic [9:0] WIN_HI = 10'(HIT_Y + HIT_WIN);

    state_t     st_q, st_d;
    slot_t      slots_q [SLOTS];
    slot_t      slots_d [SLOTS];
    logic [4:0] pat_q, pat_d;
    logic [7:0] score_q, score_d, miss_q, miss_d;
    logic       ovf_q, ovf_d;

    logic [2:0] render_hit [SLOTS];
    logic [2:0] render_or;
    logic [2:0] lane_done;
    logic [8:0] hit_cnt, miss_cnt, score_sum, miss_sum;
    logic       any_valid, spawned;

    for (genvar i = 0; i < SLOTS; i++) begin : g_render
        note_slot_render #(.NOTE_HALF(NOTE_HALF)) u_render (
            .slot      (slots_q[i]),
            .counter_x (CounterX),
            .counter_y (CounterY),
            .lane_hit  (render_hit[i])
        );
    end

    always_comb begin
        render_or = '0;
        for (int i = 0; i < SLOTS; i++) render_or = render_or | render_hit[i];
    end

    always_comb begin
        st_d      = st_q;
        slots_d   = slots_q;
        pat_d     = pat_q;
        score_d   = score_q;
        miss_d    = miss_q;
        ovf_d     = ovf_q;
        lane_done = '0;
        hit_cnt   = '0;
        miss_cnt  = '0;
        spawned   = 1'b0;
        any_valid = 1'b0;
        score_sum = '0;
        miss_sum  = '0;
        for (int i = 0; i < SLOTS; i++) any_valid = any_valid | slots_q[i].valid;

        case (st_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    slots_d = '{default: '0};
                    pat_d   = '0;
                    score_d = '0;
                    miss_d  = '0;
                    ovf_d   = 1'b0;
                    st_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // hits judge the pre-move position, lowest matching slot per lane
                for (int l = 0; l < 3; l++) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (btn_hit[l] && !lane_done[l] && slots_q[i].valid &&
                            slots_q[i].lane == 2'(l) &&
                            slots_q[i].y >= WIN_LO && slots_q[i].y <= WIN_HI) begin
                            slots_d[i].valid = 1'b0;
                            lane_done[l]     = 1'b1;
                            hit_cnt          = hit_cnt + 9'd1;
                        end
                    end
                end
                if (move_tick) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (slots_d[i].valid) begin
                            if (slots_d[i].y >= WIN_HI) begin
                                slots_d[i].valid = 1'b0;
                                miss_cnt         = miss_cnt + 9'd1;
                            end else begin
                                slots_d[i].y = slots_d[i].y + 10'd1;
                            end
                        end
                    end
                end
                // spawns only take slots that were free before this cycle's retirements
                if (beat_tick && pat_q < 5'(PAT_LEN)) begin
                    pat_d = pat_q + 5'd1;
                    if (pattern[PAT_PRESENT] && pattern[PAT_LANE_LSB +: 2] != 2'd3) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (!spawned && !slots_q[i].valid) begin
                                slots_d[i].valid = 1'b1;
                                slots_d[i].lane  = pattern[PAT_LANE_LSB +: 2];
                                slots_d[i].y     = '0;
                                spawned          = 1'b1;
                            end
                        end
                        if (!spawned) ovf_d = 1'b1;
                    end
                end
                score_sum = {1'b0, score_q} + hit_cnt;
                miss_sum  = {1'b0, miss_q} + miss_cnt;
                score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
                miss_d    = miss_sum[8]  ? 8'hFF : miss_sum[7:0];
                if (pat_q == 5'(PAT_LEN) && !any_valid) st_d = ST_DONE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= ST_IDLE;
            slots_q <= '{default: '0};
            pat_q   <= '0;
            score_q <= '0;
            miss_q  <= '0;
            ovf_q   <= 1'b0;
            lane_on <= '0;
        end else begin
            st_q    <= st_d;
            slots_q <= slots_d;
            pat_q   <= pat_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            ovf_q   <= ovf_d;
            lane_on <= render_or;
        end
    end

    assign pat_addr   = pat_q[3:0];
    assign score      = score_q;
    assign miss_count = miss_q;
    assign overflow   = ovf_q;
    assign state      = st_q;

endmodule
